// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running pixel/line counters advanced by pix_ce,
// with registered sync, blanking, coordinate and frame-pacing outputs.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap, f_wrap;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (h_wrap) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
        f_wrap = h_wrap && (v_cnt == V_LAST);
    end

    // Counters reset to their last position so the first strobe lands on (0,0);
    // outputs are decoded from the next-state values so they track the counters.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                x           <= h_nxt;
                y           <= v_nxt;
                video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
                hsync       <= ((h_nxt >= HS_BEGIN) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
                vsync       <= ((v_nxt >= VS_BEGIN) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
                line_start  <= h_wrap;
                frame_start <= f_wrap;
                if (f_wrap)
                    frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
